// File: rtl/port_rd_backend.sv
// Per-port egress stage: arbitrates among priority queues (strict or WRR), pops a packet,
// buffers SRAM words in a small FIFO and streams them out under ready. Optional RD_STATS_EN adds counters.
module port_rd_backend #(
  parameter int DATA_WIDTH = 16,
  parameter int PRIOR_NUM  = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int AF_MARGIN  = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wrr_enable,
  input  logic [PRIOR_NUM-1:0]         queue_empty,
  output logic                         pop_valid,
  output logic [$clog2(PRIOR_NUM)-1:0] pop_prior,
  input  logic                         pop_ack,
  input  logic                         xfer_data_vld,
  input  logic [DATA_WIDTH-1:0]        xfer_data,
  input  logic                         xfer_end_of_packet,
  output logic                         xfer_pause,
  input  logic                         ready,
  output logic                         rd_sop,
  output logic                         rd_eop,
  output logic                         rd_vld,
  output logic [DATA_WIDTH-1:0]        rd_data
`ifdef RD_STATS_EN
  ,
  output logic [15:0]                  stat_pkts,
  output logic [31:0]                  stat_words
`endif
);

  localparam int PW = $clog2(PRIOR_NUM);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(PRIOR_NUM + 1);
  localparam logic [AW:0] DEPTH_C  = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] MARGIN_C = (AW+1)'(AF_MARGIN);

  typedef enum logic [1:0] {S_IDLE, S_POP, S_STREAM, S_TAIL} state_t;
  state_t r_state, w_state_nxt;

  logic [DATA_WIDTH:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0]         r_wr_ptr, r_rd_ptr;
  logic [AW:0]           r_count, w_count_nxt;
  logic [CW-1:0]         r_credit [PRIOR_NUM];
  logic [PW-1:0]         r_rr_ptr, r_pop_prior;
  logic                  r_pop_valid, r_sop, r_eop, r_vld, r_pause;
  logic [DATA_WIDTH-1:0] r_data;

  logic                  w_fifo_empty, w_fifo_full, w_push, w_pop;
  logic                  w_launch, w_reload, w_grant, w_wrr_found;
  logic [PW-1:0]         w_strict_p, w_wrr_p, w_grant_p;
  logic [DATA_WIDTH:0]   w_head;

  function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] base, input int off);
    return PW'((int'(base) + off) % PRIOR_NUM);
  endfunction

  function automatic logic [CW-1:0] credit_init(input int p);
    return CW'(PRIOR_NUM - p);
  endfunction

  assign w_fifo_empty = (r_count == '0);
  assign w_fifo_full  = (r_count == DEPTH_C);
  assign w_push       = (r_state == S_STREAM) && xfer_data_vld && !w_fifo_full;
  assign w_pop        = (r_state == S_STREAM) && ready && !w_fifo_empty;
  assign w_head       = r_mem[r_rd_ptr];
  assign w_count_nxt  = r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};

  // Descending scans leave the lowest index (strict) or nearest-to-pointer entry (WRR) as the winner.
  always_comb begin
    w_strict_p  = '0;
    w_wrr_p     = r_rr_ptr;
    w_wrr_found = 1'b0;
    for (int i = PRIOR_NUM - 1; i >= 0; i--) begin
      if (!queue_empty[PW'(i)])
        w_strict_p = PW'(i);
      if (!queue_empty[wrap_idx(r_rr_ptr, i)] && (r_credit[wrap_idx(r_rr_ptr, i)] != '0)) begin
        w_wrr_p     = wrap_idx(r_rr_ptr, i);
        w_wrr_found = 1'b1;
      end
    end
  end

  assign w_launch  = (r_state == S_IDLE) && (queue_empty != '1) && w_fifo_empty;
  assign w_reload  = w_launch && wrr_enable && !w_wrr_found;
  assign w_grant   = w_launch && !w_reload;
  assign w_grant_p = wrr_enable ? w_wrr_p : w_strict_p;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_grant) w_state_nxt = S_POP;
      S_POP:    if (pop_ack) w_state_nxt = S_STREAM;
      S_STREAM: if (w_pop && w_head[DATA_WIDTH]) w_state_nxt = S_TAIL;
      S_TAIL:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Pause is derived from the next occupancy so it rises in the same cycle the count reaches the margin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pop_valid <= 1'b0;
      r_pop_prior <= '0;
      r_sop       <= 1'b0;
      r_eop       <= 1'b0;
      r_vld       <= 1'b0;
      r_data      <= '0;
      r_pause     <= 1'b0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
    end else begin
      r_pop_valid <= (w_state_nxt == S_POP);
      if (w_grant) r_pop_prior <= w_grant_p;
      r_sop       <= (r_state == S_POP) && pop_ack;
      r_eop       <= (r_state == S_TAIL);
      r_vld       <= w_pop;
      if (w_pop) begin
        r_data   <= w_head[DATA_WIDTH-1:0];
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      r_count     <= w_count_nxt;
      r_pause     <= (DEPTH_C - w_count_nxt) <= MARGIN_C;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {xfer_end_of_packet, xfer_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < PRIOR_NUM; p++) r_credit[PW'(p)] <= credit_init(p);
      r_rr_ptr <= '0;
    end else if (w_reload) begin
      for (int p = 0; p < PRIOR_NUM; p++) r_credit[PW'(p)] <= credit_init(p);
    end else if (w_grant && wrr_enable) begin
      r_credit[w_wrr_p] <= r_credit[w_wrr_p] - CW'(1);
      r_rr_ptr          <= w_wrr_p;
    end
  end

  assign pop_valid  = r_pop_valid;
  assign pop_prior  = r_pop_prior;
  assign xfer_pause = r_pause;
  assign rd_sop     = r_sop;
  assign rd_eop     = r_eop;
  assign rd_vld     = r_vld;
  assign rd_data    = r_data;

`ifdef RD_STATS_EN
  logic [15:0] r_stat_pkts;
  logic [31:0] r_stat_words;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_pkts  <= '0;
      r_stat_words <= '0;
    end else begin
      if (r_state == S_TAIL) r_stat_pkts  <= r_stat_pkts + 16'd1;
      if (w_pop)             r_stat_words <= r_stat_words + 32'd1;
    end
  end

  assign stat_pkts  = r_stat_pkts;
  assign stat_words = r_stat_words;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_port_rd_backend.sv
// Directed-plus-random bench for port_rd_backend with a behavioural arbitration and packet model.
module tb_port_rd_backend;

  logic        clk = 1'b0;
  logic        rst_n, wrr_enable, pop_ack, xfer_data_vld, xfer_end_of_packet, ready;
  logic [7:0]  queue_empty;
  logic [15:0] xfer_data;
  logic        pop_valid, xfer_pause, rd_sop, rd_eop, rd_vld;
  logic [2:0]  pop_prior;
  logic [15:0] rd_data;
`ifdef RD_STATS_EN
  logic [15:0] stat_pkts;
  logic [31:0] stat_words;
`endif

  int checks = 0;
  int failures = 0;

  // Monitor state
  logic [15:0] q_out[$];
  int cyc, push_cnt, vld_cnt, n_sop, n_eop, eop_cyc;
  int order_err, gap_err, ovf, stab_err, pause_rises, pause_occ;
  bit in_pkt, prev_pause, prev_pv;
  logic [2:0] prev_pp;

  port_rd_backend dut (
    .clk(clk), .rst_n(rst_n), .wrr_enable(wrr_enable), .queue_empty(queue_empty),
    .pop_valid(pop_valid), .pop_prior(pop_prior), .pop_ack(pop_ack),
    .xfer_data_vld(xfer_data_vld), .xfer_data(xfer_data),
    .xfer_end_of_packet(xfer_end_of_packet), .xfer_pause(xfer_pause), .ready(ready),
    .rd_sop(rd_sop), .rd_eop(rd_eop), .rd_vld(rd_vld), .rd_data(rd_data)
`ifdef RD_STATS_EN
    , .stat_pkts(stat_pkts), .stat_words(stat_words)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q_out.delete();
        cyc = 0; push_cnt = 0; vld_cnt = 0; n_sop = 0; n_eop = 0; eop_cyc = -100;
        order_err = 0; gap_err = 0; ovf = 0; stab_err = 0; pause_rises = 0; pause_occ = 0;
        in_pkt = 0; prev_pause = 0; prev_pv = 0; prev_pp = '0;
      end else begin
        cyc++;
        if (rd_sop) begin
          n_sop++;
          if (in_pkt || rd_vld) order_err++;
          if (cyc - eop_cyc < 2) gap_err++;
          in_pkt = 1;
        end
        if (rd_vld) begin
          q_out.push_back(rd_data);
          vld_cnt++;
          if (!in_pkt || rd_sop) order_err++;
        end
        if (rd_eop) begin
          n_eop++;
          if (rd_vld || !in_pkt) order_err++;
          in_pkt = 0;
          eop_cyc = cyc;
        end
        if (xfer_pause && !prev_pause) begin
          pause_rises++;
          pause_occ = push_cnt - vld_cnt;
        end
        prev_pause = xfer_pause;
        if (xfer_data_vld) begin
          if (push_cnt - vld_cnt >= 8) ovf++;
          push_cnt++;
        end
        if (pop_valid && prev_pv && pop_prior != prev_pp) stab_err++;
        prev_pv = pop_valid;
        prev_pp = pop_prior;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int lowest_zero(input logic [7:0] q);
    for (int i = 0; i < 8; i++) if (!q[i]) return i;
    return 0;
  endfunction

  // One packet: wait for the pop, ack it, stream nw words under the chosen ready/SRAM patterns, compare output.
  task automatic run_packet(input logic [7:0] qe, input int nw, input int rmode, input int smode,
                            output logic [2:0] prio);
    logic [15:0] w[$];
    int base, s0, e0, t;
    queue_empty = qe;
    t = 0;
    while (pop_valid !== 1'b1 && t < 100) begin @(posedge clk); #1; t++; end
    chk("pop_valid_wait", 32'(pop_valid), 32'd1);
    prio = pop_prior;
    if (pop_valid !== 1'b1) begin queue_empty = 8'hFF; return; end
    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    pop_ack = 1'b1;
    queue_empty = 8'hFF;
    @(posedge clk); #1;
    pop_ack = 1'b0;
    base = q_out.size(); s0 = n_sop; e0 = n_eop;
    for (int i = 0; i < nw; i++) w.push_back(16'($urandom));
    fork
      begin : sram
        int k, c;
        k = 0; c = 0;
        while (k < nw && c < 400) begin
          if (!xfer_pause && ((smode == 0) || (smode == 1 && $urandom_range(0, 3) != 0) ||
                              (smode == 2 && c % 2 == 0))) begin
            xfer_data_vld = 1'b1; xfer_data = w[k]; xfer_end_of_packet = (k == nw - 1); k++;
          end else begin
            xfer_data_vld = 1'b0; xfer_end_of_packet = 1'b0;
          end
          @(posedge clk); #1; c++;
        end
        xfer_data_vld = 1'b0; xfer_end_of_packet = 1'b0;
      end
      begin : rdy
        int c;
        c = 0;
        while (n_eop == e0 && c < 500) begin
          case (rmode)
            0:       ready = 1'b1;
            1:       ready = 1'($urandom_range(0, 1));
            2:       ready = (c % 2 == 0);
            default: ready = (c < 4 || c >= 14);
          endcase
          @(posedge clk); #1; c++;
        end
        ready = 1'b1;
      end
    join
    chk("eop_count", 32'(n_eop - e0), 32'd1);
    chk("sop_count", 32'(n_sop - s0), 32'd1);
    chk("word_count", 32'(q_out.size() - base), 32'(nw));
    for (int i = 0; i < nw; i++)
      if (base + i < q_out.size()) chk("word", 32'(q_out[base + i]), 32'(w[i]));
  endtask

  initial begin
    logic [2:0] prio;
    logic [7:0] qe;
    int pr0, t, n0, n7, exp_p, wptr;
    int cred[8];
    bit found;

    rst_n = 1'b0; wrr_enable = 1'b0; pop_ack = 1'b0; xfer_data_vld = 1'b0;
    xfer_end_of_packet = 1'b0; xfer_data = '0; ready = 1'b1; queue_empty = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pop_valid", 32'(pop_valid), 32'd0);
    chk("rst_pop_prior", 32'(pop_prior), 32'd0);
    chk("rst_pause", 32'(xfer_pause), 32'd0);
    chk("rst_sop", 32'(rd_sop), 32'd0);
    chk("rst_eop", 32'(rd_eop), 32'd0);
    chk("rst_vld", 32'(rd_vld), 32'd0);
    chk("rst_data", 32'(rd_data), 32'd0);
    rst_n = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    chk("idle_no_pop", 32'(pop_valid), 32'd0);

    // Single packet from priority 2
    run_packet(8'hFB, 4, 0, 0, prio);
    chk("single_prio", 32'(prio), 32'd2);

    // Strict mode always picks the lowest non-empty index
    for (int i = 0; i < 3; i++) begin
      run_packet(8'hDD, 3, 0, 0, prio);
      chk("strict_prio", 32'(prio), 32'd1);
    end

    // Ten-cycle stall with SRAM streaming
    pr0 = pause_rises;
    run_packet(8'hEF, 20, 3, 0, prio);
    chk("stall_prio", 32'(prio), 32'd4);
    chk("stall_pause_rose", 32'(pause_rises > pr0), 32'd1);
    chk("stall_pause_occ", 32'(pause_occ), 32'd6);

    // Alternating ready with simultaneous push and pop
    pr0 = pause_rises;
    run_packet(8'hF7, 12, 2, 2, prio);
    chk("alt_prio", 32'(prio), 32'd3);
    chk("alt_no_pause", 32'(pause_rises - pr0), 32'd0);

    // Random queue masks, lengths and flow control
    for (int i = 0; i < 6; i++) begin
      qe = 8'($urandom);
      if (qe == 8'hFF) qe = 8'h7F;
      run_packet(qe, $urandom_range(1, 12), $urandom_range(0, 1), $urandom_range(0, 1), prio);
      chk("rand_prio", 32'(prio), 32'(lowest_zero(qe)));
    end

    chk("order_errors", 32'(order_err), 32'd0);
    chk("sop_gap_errors", 32'(gap_err), 32'd0);
    chk("overflow_pushes", 32'(ovf), 32'd0);
    chk("pop_prior_stable", 32'(stab_err), 32'd0);

    // Asynchronous reset in the middle of a packet
    queue_empty = 8'hFE;
    t = 0;
    while (pop_valid !== 1'b1 && t < 100) begin @(posedge clk); #1; t++; end
    chk("rst_test_pop", 32'(pop_valid), 32'd1);
    pop_ack = 1'b1; queue_empty = 8'hFF;
    @(posedge clk); #1;
    pop_ack = 1'b0; ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      xfer_data_vld = 1'b1; xfer_data = 16'h8000 | 16'(i);
      @(posedge clk); #1;
    end
    xfer_data_vld = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk("arst_vld", 32'(rd_vld), 32'd0);
    chk("arst_data", 32'(rd_data), 32'd0);
    chk("arst_sop", 32'(rd_sop), 32'd0);
    chk("arst_eop", 32'(rd_eop), 32'd0);
    chk("arst_pop_valid", 32'(pop_valid), 32'd0);
    chk("arst_pause", 32'(xfer_pause), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    chk("arst_no_eop", 32'(n_eop), 32'd0);
    run_packet(8'hFE, 6, 0, 0, prio);
    chk("arst_next_prio", 32'(prio), 32'd0);

    // WRR between priorities 0 and 7 against a credit model
    wrr_enable = 1'b1;
    for (int p = 0; p < 8; p++) cred[p] = 8 - p;
    wptr = 0; n0 = 0; n7 = 0;
    for (int g = 0; g < 18; g++) begin
      found = 0; exp_p = 0;
      for (int pass = 0; pass < 2 && !found; pass++) begin
        for (int off = 0; off < 8 && !found; off++) begin
          int p;
          p = (wptr + off) % 8;
          if ((p == 0 || p == 7) && cred[p] > 0) begin found = 1; exp_p = p; end
        end
        if (!found) for (int p = 0; p < 8; p++) cred[p] = 8 - p;
      end
      cred[exp_p]--;
      wptr = exp_p;
      run_packet(8'h7E, 1, 0, 0, prio);
      chk("wrr_prio", 32'(prio), 32'(exp_p));
      if (prio == 3'd0) n0++;
      if (prio == 3'd7) n7++;
      if (g == 8 || g == 17) begin
        chk("wrr_round_p0", 32'(n0), 32'd8);
        chk("wrr_round_p7", 32'(n7), 32'd1);
        n0 = 0; n7 = 0;
      end
    end
    wrr_enable = 1'b0;

    chk("order_errors_end", 32'(order_err), 32'd0);
    chk("sop_gap_errors_end", 32'(gap_err), 32'd0);
    chk("overflow_pushes_end", 32'(ovf), 32'd0);

`ifdef RD_STATS_EN
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) run_packet(8'hFD, 5, 0, 0, prio);
    repeat (2) begin @(posedge clk); #1; end
    chk("stat_pkts", 32'(stat_pkts), 32'd3);
    chk("stat_words", stat_words, 32'd15);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
